des_job_scheduler: RTL and testbench

//  Sequences the 64x64 key/message store for the DES core. Host pushes (key,msg) jobs; block writes

---
 rtl/des_sched_pkg.sv | 24 ++
 rtl/des_ring_ptr.sv | 50 +++++
 rtl/des_job_scheduler.sv | 175 +++++++++++++++++
 tb/tb_des_job_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_sched_pkg.sv
// Shared types and constants for the DES job scheduler.
// Contents: FSM state enum, ring/memory/data sizes, slot-to-address helper.
package des_sched_pkg;

  localparam int DEPTH_JOBS = 32;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 64;
  localparam int PTR_W      = 5;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    LATCH   = 2'd2,
    BUSY    = 2'd3
  } state_t;

  // Each slot owns two adjacent words: key at 2*i, message at 2*i+1.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [PTR_W-1:0] slot,
                                                  input logic             is_msg);
    return {slot, is_msg};
  endfunction

endpackage

// File: rtl/des_ring_ptr.sv
// Ring bookkeeping for the job store: write/read slot pointers and occupancy.
// Ports:
//   i_clk, i_rst         clock, async active-high reset
//   i_push, i_pop        advance write / read pointer (may coincide)
//   o_wr_ptr, o_rd_ptr   current slot indices
//   o_count              jobs stored and not yet launched
//   o_full, o_empty      occupancy flags
import des_sched_pkg::*;

module des_ring_ptr (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH_JOBS - 1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_full   = (r_count == CNT_W'(DEPTH_JOBS));
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/des_job_scheduler.sv
// Job scheduler between host, key/message memory and the DES core.
// Host jobs are written into a ring of memory slots, then read back in FIFO
// order and launched on the DES core with a start/done handshake.
// Ports:
//   i_clk, i_rst                       clock, async active-high reset
//   i_host_valid/o_host_ready          job handshake; i_host_key, i_host_msg job data
//   o_des_start, o_des_key, o_des_msg  launch pulse and operands; o_des_job_id slot index
//   i_des_done                         completion pulse (honoured only in BUSY)
//   o_mem_en, o_mem_wr0_n, o_mem_wr1_n memory control (wr1_n held high)
//   o_mem_add0/1, o_mem_key_wr/msg_wr  addresses and write data
//   i_mem_key_rd, i_mem_msg_rd         read data, valid the cycle after the read request
//   o_q_count, o_q_full, o_q_empty     ring occupancy
// Build option DES_SCHED_STATS_EN: adds o_stat_accepted / o_stat_completed
// saturating counters.
import des_sched_pkg::*;

module des_job_scheduler (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_host_valid,
  output logic              o_host_ready,
  input  logic [DATA_W-1:0] i_host_key,
  input  logic [DATA_W-1:0] i_host_msg,
  output logic              o_des_start,
  output logic [DATA_W-1:0] o_des_key,
  output logic [DATA_W-1:0] o_des_msg,
  output logic [4:0]        o_des_job_id,
  input  logic              i_des_done,
  output logic              o_mem_en,
  output logic              o_mem_wr0_n,
  output logic              o_mem_wr1_n,
  output logic [ADDR_W-1:0] o_mem_add0,
  output logic [ADDR_W-1:0] o_mem_add1,
  output logic [DATA_W-1:0] o_mem_key_wr,
  output logic [DATA_W-1:0] o_mem_msg_wr,
  input  logic [DATA_W-1:0] i_mem_key_rd,
  input  logic [DATA_W-1:0] i_mem_msg_rd,
  output logic [5:0]        o_q_count,
  output logic              o_q_full,
  output logic              o_q_empty
`ifdef DES_SCHED_STATS_EN
  ,
  output logic [15:0]       o_stat_accepted,
  output logic [15:0]       o_stat_completed
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_ready;
  logic             w_rd_req;
  logic             w_pop;
  logic             w_push;
  logic             w_done_ok;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;

  logic              r_des_start;
  logic [DATA_W-1:0] r_des_key;
  logic [DATA_W-1:0] r_des_msg;
  logic [4:0]        r_des_job_id;

  des_ring_ptr u_ring (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_rd_req    = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        // A pending launch beats a new host write for the single memory port.
        if (!w_empty) begin
          w_rd_req    = 1'b1;
          w_state_nxt = RD_WAIT;
        end else begin
          w_ready = !w_full;
        end
      end
      RD_WAIT: w_state_nxt = LATCH;
      LATCH: begin
        w_pop       = 1'b1;
        w_state_nxt = BUSY;
      end
      BUSY: begin
        w_ready = !w_full;
        if (i_des_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ready is held low while reset is applied so the host sees no acceptance.
  assign o_host_ready = w_ready & ~i_rst;
  assign w_push       = i_host_valid & o_host_ready;
  assign w_done_ok    = (r_state == BUSY) & i_des_done;

  assign o_mem_en     = w_push | w_rd_req;
  assign o_mem_wr0_n  = ~w_push;
  assign o_mem_wr1_n  = 1'b1;
  assign o_mem_add0   = w_push   ? slot_addr(w_wr_ptr, 1'b0) :
                        w_rd_req ? slot_addr(w_rd_ptr, 1'b0) : '0;
  assign o_mem_add1   = w_push   ? slot_addr(w_wr_ptr, 1'b1) :
                        w_rd_req ? slot_addr(w_rd_ptr, 1'b1) : '0;
  assign o_mem_key_wr = w_push ? i_host_key : '0;
  assign o_mem_msg_wr = w_push ? i_host_msg : '0;

  // Read data is present during RD_WAIT; registering it on that edge puts the
  // operands and the start pulse out together during LATCH (2 cycles after the
  // request), and the operands then hold until the next launch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_des_start  <= 1'b0;
      r_des_key    <= '0;
      r_des_msg    <= '0;
      r_des_job_id <= '0;
    end else begin
      r_des_start <= (r_state == RD_WAIT);
      if (r_state == RD_WAIT) begin
        r_des_key    <= i_mem_key_rd;
        r_des_msg    <= i_mem_msg_rd;
        r_des_job_id <= 5'(w_rd_ptr);
      end
    end
  end

  assign o_des_start  = r_des_start;
  assign o_des_key    = r_des_key;
  assign o_des_msg    = r_des_msg;
  assign o_des_job_id = r_des_job_id;
  assign o_q_count    = 6'(w_count);
  assign o_q_full     = w_full;
  assign o_q_empty    = w_empty;

`ifdef DES_SCHED_STATS_EN
  logic [15:0] r_stat_accepted;
  logic [15:0] r_stat_completed;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_accepted  <= '0;
      r_stat_completed <= '0;
    end else begin
      if (w_push && r_stat_accepted != 16'hFFFF)     r_stat_accepted  <= r_stat_accepted + 1'b1;
      if (w_done_ok && r_stat_completed != 16'hFFFF) r_stat_completed <= r_stat_completed + 1'b1;
    end
  end

  assign o_stat_accepted  = r_stat_accepted;
  assign o_stat_completed = r_stat_completed;
`else
  // Without statistics the accepted-done qualifier has no consumer.
  logic w_unused_done;
  assign w_unused_done = w_done_ok;
`endif

endmodule

// File: tb/tb_des_job_scheduler.sv
module tb_des_job_scheduler;

  logic        clk;
  logic        rst;
  logic        host_valid;
  logic        host_ready;
  logic [63:0] host_key;
  logic [63:0] host_msg;
  logic        des_start;
  logic [63:0] des_key;
  logic [63:0] des_msg;
  logic [4:0]  des_job_id;
  logic        des_done;
  logic        mem_en;
  logic        mem_wr0_n;
  logic        mem_wr1_n;
  logic [5:0]  mem_add0;
  logic [5:0]  mem_add1;
  logic [63:0] mem_key_wr;
  logic [63:0] mem_msg_wr;
  logic [63:0] mem_key_rd;
  logic [63:0] mem_msg_rd;
  logic [5:0]  q_count;
  logic        q_full;
  logic        q_empty;
`ifdef DES_SCHED_STATS_EN
  logic [15:0] stat_accepted;
  logic [15:0] stat_completed;
`endif

  des_job_scheduler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_host_valid (host_valid),
    .o_host_ready (host_ready),
    .i_host_key   (host_key),
    .i_host_msg   (host_msg),
    .o_des_start  (des_start),
    .o_des_key    (des_key),
    .o_des_msg    (des_msg),
    .o_des_job_id (des_job_id),
    .i_des_done   (des_done),
    .o_mem_en     (mem_en),
    .o_mem_wr0_n  (mem_wr0_n),
    .o_mem_wr1_n  (mem_wr1_n),
    .o_mem_add0   (mem_add0),
    .o_mem_add1   (mem_add1),
    .o_mem_key_wr (mem_key_wr),
    .o_mem_msg_wr (mem_msg_wr),
    .i_mem_key_rd (mem_key_rd),
    .i_mem_msg_rd (mem_msg_rd),
    .o_q_count    (q_count),
    .o_q_full     (q_full),
    .o_q_empty    (q_empty)
`ifdef DES_SCHED_STATS_EN
    ,
    .o_stat_accepted  (stat_accepted),
    .o_stat_completed (stat_completed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: write both words, or register both read words.
  logic [63:0] mem [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (!mem_wr0_n) begin
        mem[mem_add0] <= mem_key_wr;
        mem[mem_add1] <= mem_msg_wr;
      end else begin
        mem_key_rd <= mem[mem_add0];
        mem_msg_rd <= mem[mem_add1];
      end
    end
  end

  typedef struct {
    logic [63:0] key;
    logic [63:0] msg;
    logic [4:0]  id;
    logic [5:0]  add0;
  } vec_t;

  vec_t tab[42];
  int   n_vec = 0;
  int   n_err = 0;
  int   pushed = 0;
  int   launched = 0;
  int   lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer job k, wait (bounded) for acceptance, check the write cycle.
  task automatic push(input int k);
    int budget;
    budget = 0;
    host_valid = 1'b1;
    host_key   = tab[k].key;
    host_msg   = tab[k].msg;
    #1;
    while (!host_ready && budget < 200) begin
      @(posedge clk);
      #2;
      budget++;
    end
    check("push_accept", 64'(host_ready), 64'd1);
    check("wr_en",   64'(mem_en),     64'd1);
    check("wr_n",    64'(mem_wr0_n),  64'd0);
    check("wr_add0", 64'(mem_add0),   64'(tab[k].add0));
    check("wr_add1", 64'(mem_add1),   64'(tab[k].add0) + 64'd1);
    check("wr_key",  mem_key_wr,      tab[k].key);
    step();
    host_valid = 1'b0;
  endtask

  // Wait (bounded) for des_start; lat counts beats already spent by caller.
  task automatic wait_start();
    while (!des_start && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic check_launch(input int k);
    check("start",  64'(des_start),  64'd1);
    check("job_id", 64'(des_job_id), 64'(tab[k].id));
    check("key",    des_key,         tab[k].key);
    check("msg",    des_msg,         tab[k].msg);
  endtask

  initial begin
    tab[0].key = 64'h133457799BBCDFF1;
    tab[0].msg = 64'h0123456789ABCDEF;
    tab[0].id  = 5'd0;
    tab[0].add0 = 6'd0;
    for (int k = 1; k < 42; k++) begin
      tab[k].key  = {32'hA5A50000 + 32'(k), 32'h10000000 + 32'(k)};
      tab[k].msg  = ~tab[k].key;
      tab[k].id   = 5'(k % 32);
      tab[k].add0 = 6'(2 * (k % 32));
    end

    rst = 1'b1; host_valid = 1'b0; host_key = '0; host_msg = '0; des_done = 1'b0;
    step();
    // Reset state
    check("rst_ready",  64'(host_ready), 64'd0);
    check("rst_start",  64'(des_start),  64'd0);
    check("rst_mem_en", 64'(mem_en),     64'd0);
    check("rst_wr0_n",  64'(mem_wr0_n),  64'd1);
    check("rst_wr1_n",  64'(mem_wr1_n),  64'd1);
    check("rst_count",  64'(q_count),    64'd0);
    check("rst_empty",  64'(q_empty),    64'd1);
    check("rst_full",   64'(q_full),     64'd0);
    rst = 1'b0;
    step();

    // Test 1: single job, write at 0/1, read then launch 2 cycles later
    push(0); pushed++;
    #1;
    check("rd_en",    64'(mem_en),     64'd1);
    check("rd_wr_n",  64'(mem_wr0_n),  64'd1);
    check("rd_add0",  64'(mem_add0),   64'd0);
    check("rd_add1",  64'(mem_add1),   64'd1);
    check("rd_ready", 64'(host_ready), 64'd0);
    step();
    check("start_early", 64'(des_start), 64'd0);
    step();
    check_launch(0);
    launched++;
    step();
    check("start_pulse", 64'(des_start),  64'd0);
    check("busy_ready",  64'(host_ready), 64'd1);

    // Test 2: fill the ring while the core is busy
    for (int k = 1; k <= 32; k++) begin
      push(k); pushed++;
      if (k == 31) begin
        check("cnt31",  64'(q_count), 64'd31);
        check("full31", 64'(q_full),  64'd0);
      end
    end
    #1;
    check("cnt32",      64'(q_count),    64'd32);
    check("full32",     64'(q_full),     64'd1);
    check("full_ready", 64'(host_ready), 64'd0);
    check("full_empty", 64'(q_empty),    64'd0);

    // Test 3: drain through with pointer wrap, FIFO order, done->start = 3
    for (int k = 1; k <= 39; k++) begin
      des_done = 1'b1;
      step();
      des_done = 1'b0;
      #1;
      check("drain_rd_en",   64'(mem_en),    64'd1);
      check("drain_rd_wr_n", 64'(mem_wr0_n), 64'd1);
      check("drain_rd_add0", 64'(mem_add0),  64'(tab[k].add0));
      lat = 1;
      wait_start();
      check("done_to_start", 64'(lat), 64'd3);
      check_launch(k);
      launched++;
      step();
      check("drain_cnt", 64'(q_count), 64'(pushed - launched));
      if (k <= 7) begin
        push(k + 32); pushed++;
      end
    end
    check("drained_empty", 64'(q_empty), 64'd1);

    // Test 4: host push and des_done in the same BUSY cycle
    host_valid = 1'b1; host_key = tab[40].key; host_msg = tab[40].msg; des_done = 1'b1;
    #1;
    check("both_ready", 64'(host_ready), 64'd1);
    check("both_add0",  64'(mem_add0),   64'(tab[40].add0));
    check("both_wr_n",  64'(mem_wr0_n),  64'd0);
    step();
    host_valid = 1'b0; des_done = 1'b0;
    #1;
    check("both_cnt",     64'(q_count),  64'd1);
    check("both_idle_rd", 64'(mem_en),   64'd1);
    check("both_rd_add0", 64'(mem_add0), 64'(tab[40].add0));
    lat = 1;
    wait_start();
    check("both_lat", 64'(lat), 64'd3);
    check_launch(40);
    step();

    // Test 5: reset while BUSY with a job queued, stray done afterwards
    push(41);
    check("pre_rst_cnt", 64'(q_count), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_start", 64'(des_start),  64'd0);
    check("arst_key",   des_key,         64'd0);
    check("arst_msg",   des_msg,         64'd0);
    check("arst_id",    64'(des_job_id), 64'd0);
    check("arst_cnt",   64'(q_count),    64'd0);
    check("arst_empty", 64'(q_empty),    64'd1);
    check("arst_ready", 64'(host_ready), 64'd0);
    check("arst_en",    64'(mem_en),     64'd0);
    check("arst_wr0",   64'(mem_wr0_n),  64'd1);
    check("arst_add0",  64'(mem_add0),   64'd0);
    step();
    rst = 1'b0;
    des_done = 1'b1;
    step();
    des_done = 1'b0;
    #1;
    check("stray_cnt",   64'(q_count),    64'd0);
    check("stray_ready", 64'(host_ready), 64'd1);
    check("stray_start", 64'(des_start),  64'd0);
    check("stray_en",    64'(mem_en),     64'd0);
    step();
    check("stray_start2", 64'(des_start), 64'd0);
    push(0);
    #1;
    check("post_rst_rd_add0", 64'(mem_add0), 64'd0);
    lat = 0;
    wait_start();
    check_launch(0);

`ifdef DES_SCHED_STATS_EN
    // Test 6: 3 pushes, 2 accepted completions
    rst = 1'b1;
    step();
    check("stat_acc_rst", 64'(stat_accepted),  64'd0);
    check("stat_cmp_rst", 64'(stat_completed), 64'd0);
    rst = 1'b0;
    step();
    push(0);
    lat = 0;
    wait_start();
    step();
    push(1);
    push(2);
    for (int i = 0; i < 2; i++) begin
      des_done = 1'b1;
      step();
      des_done = 1'b0;
      lat = 0;
      wait_start();
      step();
    end
    check("stat_accepted",  64'(stat_accepted),  64'd3);
    check("stat_completed", 64'(stat_completed), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
